// File: rtl/pid_plant_model.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pid_plant_model                                                  |
// | Purpose  : First-order lag plant behind a transport delay, with disturbance. |
// |            Optional measurement noise when PLANT_NOISE_EN is defined.       |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module pid_plant_model #(
  parameter int WIDTH       = 16,
  parameter int DELAY       = 4,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] ctrl_in,
  input  logic                    ctrl_valid,
  input  logic signed [WIDTH-1:0] disturbance,
  output logic signed [WIDTH-1:0] feedback,
  output logic                    fb_valid,
  output logic                    primed,
  output logic                    sat_flag
);

  localparam int c_ptr_w = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int c_cnt_w = $clog2(DELAY + 1);
  localparam int c_ext_w = WIDTH + 2;

  localparam logic [c_ptr_w-1:0]        c_ptr_last  = c_ptr_w'(DELAY - 1);
  localparam logic [c_cnt_w-1:0]        c_fill_last = c_cnt_w'(DELAY - 1);
  localparam logic signed [c_ext_w-1:0] c_max       = c_ext_w'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [c_ext_w-1:0] c_min       = ~c_max;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic signed [WIDTH-1:0]    r_mem [DELAY];
  logic [c_ptr_w-1:0]         r_wr_ptr;
  logic [c_cnt_w-1:0]         r_fill_cnt;
  logic signed [WIDTH-1:0]    r_y;
  logic signed [WIDTH-1:0]    r_feedback;
  logic                       r_fb_valid;
  logic                       r_sat;

  logic                       w_accept;
  logic signed [c_ext_w-1:0]  w_ud;
  logic signed [c_ext_w-1:0]  w_e;
  logic signed [c_ext_w-1:0]  w_step;
  logic signed [c_ext_w-1:0]  w_sum;
  logic signed [c_ext_w-1:0]  w_noise;
  logic signed [c_ext_w-1:0]  w_fb_raw;
  logic signed [WIDTH-1:0]    w_y_new;
  logic signed [WIDTH-1:0]    w_fb_new;
  logic                       w_y_clamped;
  logic                       w_fb_clamped;

  function automatic logic signed [c_ext_w-1:0] sext(input logic signed [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic signed [WIDTH-1:0] clamp(input logic signed [c_ext_w-1:0] v);
    if (v > c_max) return c_max[WIDTH-1:0];
    if (v < c_min) return c_min[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  assign w_accept = ctrl_valid;

  // Delay-line storage is deliberately not reset; the FILL state hides stale entries.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= ctrl_in;
    end
  end

`ifdef PLANT_NOISE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Noise uses the LFSR value current at the accepting edge, i.e. -8..+7.
  assign w_noise = $signed({{(c_ext_w - 4){1'b0}}, r_lfsr[3:0]}) - c_ext_w'(8);
`else
  assign w_noise = '0;
`endif

  always_comb begin
    w_ud = '0;
    if (r_state == S_RUN) begin
      w_ud = sext(r_mem[r_wr_ptr]);
    end
    w_e          = w_ud + sext(disturbance) - sext(r_y);
    w_step       = w_e >>> ALPHA_SHIFT;
    w_sum        = sext(r_y) + w_step;
    w_y_new      = clamp(w_sum);
    w_y_clamped  = (w_sum > c_max) || (w_sum < c_min);
    w_fb_raw     = sext(w_y_new) + w_noise;
    w_fb_new     = clamp(w_fb_raw);
    w_fb_clamped = (w_fb_raw > c_max) || (w_fb_raw < c_min);
  end

  always_comb begin
    w_state_next = r_state;
    if ((r_state == S_FILL) && w_accept && (r_fill_cnt == c_fill_last)) begin
      w_state_next = S_RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_y        <= '0;
      r_feedback <= '0;
      r_fb_valid <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_fb_valid <= w_accept;
      if (w_accept) begin
        r_wr_ptr   <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
        r_fill_cnt <= (r_state == S_FILL) ? r_fill_cnt + 1'b1 : r_fill_cnt;
        r_y        <= w_y_new;
        r_feedback <= w_fb_new;
        r_sat      <= w_y_clamped | w_fb_clamped;
      end
    end
  end

  assign feedback = r_feedback;
  assign fb_valid = r_fb_valid;
  assign primed   = (r_state == S_RUN);
  assign sat_flag = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_pid_plant_model.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_pid_plant_model                                               |
// | Purpose  : Self-checking bench for pid_plant_model (ALPHA_SHIFT 2 and 0).   |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_pid_plant_model;

  localparam int DELAY = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               ctrl_valid;
  logic signed [15:0] ctrl_in;
  logic signed [15:0] disturbance;
  logic signed [15:0] fb2, fb0;
  logic               v2, v0, p2, p0, s2, s0;

  always #5 clk = ~clk;

  pid_plant_model #(.WIDTH(16), .DELAY(DELAY), .ALPHA_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
    .disturbance(disturbance), .feedback(fb2), .fb_valid(v2), .primed(p2), .sat_flag(s2)
  );

  pid_plant_model #(.WIDTH(16), .DELAY(DELAY), .ALPHA_SHIFT(0)) dut_a0 (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid),
    .disturbance(disturbance), .feedback(fb0), .fb_valid(v0), .primed(p0), .sat_flag(s0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history queue of accepted inputs, one lag state per instance.
  int hist[$];
  int acc_cnt;
  int my[2];
  int mfb[2];
  int msat[2];
  int lfsr;

  function automatic int clampw(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  task automatic model_reset();
    hist.delete();
    acc_cnt = 0;
    lfsr    = 'hACE1;
    for (int k = 0; k < 2; k++) begin
      my[k] = 0; mfb[k] = 0; msat[k] = 0;
    end
  endtask

  task automatic model_accept(input int c, input int d);
    int ud, e, sum, yn, f, noise, fbit;
    ud = 0;
    if (hist.size() == DELAY) ud = hist.pop_front();
    hist.push_back(c);
    acc_cnt++;
    noise = 0;
`ifdef PLANT_NOISE_EN
    noise = (lfsr % 16) - 8;
    fbit  = ((lfsr >> 15) ^ (lfsr >> 13) ^ (lfsr >> 12) ^ (lfsr >> 10)) & 1;
    lfsr  = ((lfsr << 1) | fbit) & 'hFFFF;
`else
    fbit  = 0;
`endif
    for (int k = 0; k < 2; k++) begin
      e       = ud + d - my[k];
      sum     = my[k] + floor_div(e, (k == 0) ? 4 : 1);
      yn      = clampw(sum);
      f       = clampw(yn + noise);
      msat[k] = ((yn != sum) || (f != yn + noise)) ? 1 : fbit * 0;
      my[k]   = yn;
      mfb[k]  = f;
    end
  endtask

  task automatic compare_all(input int expv);
    int expp;
    expp = (acc_cnt >= DELAY) ? 1 : 0;
    check("fb_valid_a2", v2, expv);
    check("fb_valid_a0", v0, expv);
    check("feedback_a2", fb2, mfb[0]);
    check("feedback_a0", fb0, mfb[1]);
    check("sat_flag_a2", s2, msat[0]);
    check("sat_flag_a0", s0, msat[1]);
    check("primed_a2", p2, expp);
    check("primed_a0", p0, expp);
  endtask

  task automatic step(input bit v, input int c, input int d);
    ctrl_valid  = v;
    ctrl_in     = 16'(c);
    disturbance = 16'(d);
    @(posedge clk);
    #1;
    if (v) model_accept(c, d);
    compare_all(v ? 1 : 0);
  endtask

  task automatic do_reset();
    ctrl_valid = 1'b0;
    reset      = 1'b1;
    #1;
    model_reset();
    compare_all(0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int rec[20];

  initial begin
    ctrl_valid  = 1'b0;
    ctrl_in     = '0;
    disturbance = '0;
    model_reset();
    do_reset();

    // Step response
    for (int i = 1; i <= 7; i++) begin
      step(1, 100, 0);
`ifndef PLANT_NOISE_EN
      if (i <= 4) check("step_fill", fb2, 0);
      if (i == 5) check("step_s5", fb2, 25);
      if (i == 6) check("step_s6", fb2, 43);
      if (i == 7) check("step_s7", fb2, 57);
`endif
    end

    // Asynchronous reset mid-run
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 100, 0);
    ctrl_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all(0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1, 100, 0);
`ifndef PLANT_NOISE_EN
      if (i <= 4) check("rst_stale_hidden", fb2, 0);
      if (i == 5) check("rst_s5", fb2, 25);
`endif
    end

    // Negative step
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1, -100, 0);
`ifndef PLANT_NOISE_EN
      if (i == 5) check("neg_s5", fb2, -25);
      if (i == 6) check("neg_s6", fb2, -44);
`endif
    end

    // Gapped strobe
    do_reset();
    for (int s = 1; s <= 7; s++) begin
      step(1, 100, 0);
      step(0, 0, 0);
      step(0, 0, 0);
`ifndef PLANT_NOISE_EN
      if (s == 7) check("gap_s7_hold", fb2, 57);
`endif
    end

    // Saturation on the ALPHA_SHIFT=0 instance
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, 32767, 0);
    step(1, 32767, 32767);
`ifndef PLANT_NOISE_EN
    check("sat_fb", fb0, 32767);
`endif
    check("sat_flag", s0, 1);

    // Randomized traffic with occasional extremes and resets
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int c, d;
      c = int'($urandom_range(0, 65535)) - 32768;
      d = int'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 7) == 0) c = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      if ($urandom_range(0, 3) == 0) d = 0;
      if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 200)) - 100;
      step($urandom_range(0, 3) != 0, c, d);
      if ((i % 200) == 199) do_reset();
    end

`ifdef PLANT_NOISE_EN
    // Noise bounded and reproducible from reset
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      rec[i] = fb2;
      check("noise_range", ((fb2 >= -8) && (fb2 <= 7)) ? 1 : 0, 1);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      check("noise_repeat", fb2, rec[i]);
    end
`else
    rec[0] = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
